// File: rtl/fft_16_point.sv
// 16-point radix-2 DIT complex FFT, 18-bit wrapping fixed point.
// One butterfly stage per clock; natural-order bins and a done pulse.
module fft_16_point (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [35:0] in0,
  input  logic [35:0] in1,
  input  logic [35:0] in2,
  input  logic [35:0] in3,
  input  logic [35:0] in4,
  input  logic [35:0] in5,
  input  logic [35:0] in6,
  input  logic [35:0] in7,
  input  logic [35:0] in8,
  input  logic [35:0] in9,
  input  logic [35:0] in10,
  input  logic [35:0] in11,
  input  logic [35:0] in12,
  input  logic [35:0] in13,
  input  logic [35:0] in14,
  input  logic [35:0] in15,
  output logic [35:0] out0,
  output logic [35:0] out1,
  output logic [35:0] out2,
  output logic [35:0] out3,
  output logic [35:0] out4,
  output logic [35:0] out5,
  output logic [35:0] out6,
  output logic [35:0] out7,
  output logic [35:0] out8,
  output logic [35:0] out9,
  output logic [35:0] out10,
  output logic [35:0] out11,
  output logic [35:0] out12,
  output logic [35:0] out13,
  output logic [35:0] out14,
  output logic [35:0] out15,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  stage;
  logic [35:0] ins  [16];
  logic [35:0] work [16];
  logic [35:0] nxt  [16];
  logic [35:0] res  [16];

  assign ins[0]  = in0;
  assign ins[1]  = in1;
  assign ins[2]  = in2;
  assign ins[3]  = in3;
  assign ins[4]  = in4;
  assign ins[5]  = in5;
  assign ins[6]  = in6;
  assign ins[7]  = in7;
  assign ins[8]  = in8;
  assign ins[9]  = in9;
  assign ins[10] = in10;
  assign ins[11] = in11;
  assign ins[12] = in12;
  assign ins[13] = in13;
  assign ins[14] = in14;
  assign ins[15] = in15;

  assign out0  = res[0];
  assign out1  = res[1];
  assign out2  = res[2];
  assign out3  = res[3];
  assign out4  = res[4];
  assign out5  = res[5];
  assign out6  = res[6];
  assign out7  = res[7];
  assign out8  = res[8];
  assign out9  = res[9];
  assign out10 = res[10];
  assign out11 = res[11];
  assign out12 = res[12];
  assign out13 = res[13];
  assign out14 = res[14];
  assign out15 = res[15];

  function automatic logic [3:0] bitrev(input logic [3:0] n);
    return {n[0], n[1], n[2], n[3]};
  endfunction

  // Upper leg of butterfly g: insert a 0 at bit position s.
  function automatic logic [3:0] top_idx(
    input logic [2:0] g,
    input logic [1:0] s
  );
    case (s)
      2'd0:    top_idx = {g, 1'b0};
      2'd1:    top_idx = {g[2:1], 1'b0, g[0]};
      2'd2:    top_idx = {g[2], 1'b0, g[1:0]};
      default: top_idx = {1'b0, g};
    endcase
  endfunction

  function automatic logic [3:0] bot_idx(
    input logic [2:0] g,
    input logic [1:0] s
  );
    return top_idx(g, s) | (4'd1 << s);
  endfunction

  // Twiddle exponent: position within group times 8>>s.
  function automatic logic [2:0] tw_idx(
    input logic [2:0] g,
    input logic [1:0] s
  );
    case (s)
      2'd0:    tw_idx = 3'd0;
      2'd1:    tw_idx = {g[0], 2'b00};
      2'd2:    tw_idx = {g[1:0], 1'b0};
      default: tw_idx = g;
    endcase
  endfunction

  // W^m = cos - j*sin in Q2.16, packed {re, im}.
  function automatic logic [35:0] twiddle(input logic [2:0] m);
    case (m)
      3'd0:    twiddle = {18'sd65536, 18'sd0};
      3'd1:    twiddle = {18'sd60547, -18'sd25080};
      3'd2:    twiddle = {18'sd46341, -18'sd46341};
      3'd3:    twiddle = {18'sd25080, -18'sd60547};
      3'd4:    twiddle = {18'sd0, -18'sd65536};
      3'd5:    twiddle = {-18'sd25080, -18'sd60547};
      3'd6:    twiddle = {-18'sd46341, -18'sd46341};
      default: twiddle = {-18'sd60547, -18'sd25080};
    endcase
  endfunction

  function automatic logic [33:0] sx(input logic [17:0] v);
    return {{16{v[17]}}, v};
  endfunction

  // Full-precision product, round half up, keep bits [33:16].
  function automatic logic [35:0] cmul(
    input logic [35:0] b,
    input logic [35:0] w
  );
    logic [33:0] pr;
    logic [33:0] pi;
    pr = sx(b[35:18]) * sx(w[35:18])
       - sx(b[17:0]) * sx(w[17:0]) + 34'd32768;
    pi = sx(b[35:18]) * sx(w[17:0])
       + sx(b[17:0]) * sx(w[35:18]) + 34'd32768;
    return {pr[33:16], pi[33:16]};
  endfunction

  function automatic logic [35:0] add_c(
    input logic [35:0] a,
    input logic [35:0] p
  );
    return {a[35:18] + p[35:18], a[17:0] + p[17:0]};
  endfunction

  function automatic logic [35:0] sub_c(
    input logic [35:0] a,
    input logic [35:0] p
  );
    return {a[35:18] - p[35:18], a[17:0] - p[17:0]};
  endfunction

  // All eight butterflies of the current stage.
  always_comb begin
    for (int i = 0; i < 16; i++) nxt[i] = work[i];
    for (int g = 0; g < 8; g++) begin
      nxt[top_idx(3'(g), stage)] = add_c(
        work[top_idx(3'(g), stage)],
        cmul(work[bot_idx(3'(g), stage)],
             twiddle(tw_idx(3'(g), stage))));
      nxt[bot_idx(3'(g), stage)] = sub_c(
        work[top_idx(3'(g), stage)],
        cmul(work[bot_idx(3'(g), stage)],
             twiddle(tw_idx(3'(g), stage))));
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (stage == 2'd3) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Capture, stage stepping and result/done registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage <= 2'd0;
      done  <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        work[i] <= '0;
        res[i]  <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            stage <= 2'd0;
            for (int n = 0; n < 16; n++)
              work[bitrev(4'(n))] <= ins[n];
          end
        end
        S_RUN: begin
          stage <= stage + 2'd1;
          for (int i = 0; i < 16; i++) work[i] <= nxt[i];
          if (stage == 2'd3) begin
            done <= 1'b1;
            for (int i = 0; i < 16; i++) res[i] <= nxt[i];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_16_point.sv
// Bench for fft_16_point: directed patterns, random frames vs model.
// Also checks latency, done period, mid-run reset and accuracy.
module tb_fft_16_point;

  typedef logic [35:0] vec_t [16];

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [35:0] xin  [16];
  logic [35:0] xout [16];
  logic        done;

  int compared   = 0;
  int mismatched = 0;

  fft_16_point dut (
    .clk(clk), .reset(reset), .start(start),
    .in0(xin[0]), .in1(xin[1]), .in2(xin[2]), .in3(xin[3]),
    .in4(xin[4]), .in5(xin[5]), .in6(xin[6]), .in7(xin[7]),
    .in8(xin[8]), .in9(xin[9]), .in10(xin[10]), .in11(xin[11]),
    .in12(xin[12]), .in13(xin[13]), .in14(xin[14]), .in15(xin[15]),
    .out0(xout[0]), .out1(xout[1]), .out2(xout[2]), .out3(xout[3]),
    .out4(xout[4]), .out5(xout[5]), .out6(xout[6]), .out7(xout[7]),
    .out8(xout[8]), .out9(xout[9]), .out10(xout[10]),
    .out11(xout[11]), .out12(xout[12]), .out13(xout[13]),
    .out14(xout[14]), .out15(xout[15]),
    .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [35:0] pk(input int r, input int i);
    logic [17:0] a;
    logic [17:0] b;
    a = r[17:0];
    b = i[17:0];
    return {a, b};
  endfunction

  function automatic int re_of(input logic [35:0] v);
    return int'($signed(v[35:18]));
  endfunction

  function automatic int im_of(input logic [35:0] v);
    return int'($signed(v[17:0]));
  endfunction

  function automatic int wrap18(input longint v);
    logic [17:0] t;
    t = v[17:0];
    return int'($signed(t));
  endfunction

  // Reference: textbook iterative DIT FFT on integer arrays.
  task automatic model(input vec_t x, output vec_t y);
    int re [16];
    int im [16];
    int ct [8] = '{65536, 60547, 46341, 25080, 0,
                   -25080, -46341, -60547};
    int st [8] = '{0, 25080, 46341, 60547, 65536,
                   60547, 46341, 25080};
    for (int n = 0; n < 16; n++) begin
      int r = 0;
      for (int b = 0; b < 4; b++)
        if ((n >> b) & 1) r = r | (8 >> b);
      re[r] = re_of(x[n]);
      im[r] = im_of(x[n]);
    end
    for (int s = 0; s < 4; s++) begin
      int h = 1 << s;
      for (int base = 0; base < 16; base += 2 * h) begin
        for (int j = 0; j < h; j++) begin
          int a = base + j;
          int b = base + j + h;
          int m = j * (8 >> s);
          longint wr = ct[m];
          longint wi = -st[m];
          longint pr = longint'(re[b]) * wr - longint'(im[b]) * wi;
          longint pi = longint'(re[b]) * wi + longint'(im[b]) * wr;
          int qr = wrap18((pr + 32768) >>> 16);
          int qi = wrap18((pi + 32768) >>> 16);
          int ar = re[a];
          int ai = im[a];
          re[a] = wrap18(ar + qr);
          im[a] = wrap18(ai + qi);
          re[b] = wrap18(ar - qr);
          im[b] = wrap18(ai - qi);
        end
      end
    end
    for (int k = 0; k < 16; k++) y[k] = pk(re[k], im[k]);
  endtask

  function automatic real dft_re(input vec_t x, input int k);
    real acc = 0.0;
    for (int n = 0; n < 16; n++) begin
      real ang = 2.0 * 3.141592653589793 * n * k / 16.0;
      acc += re_of(x[n]) * $cos(ang) + im_of(x[n]) * $sin(ang);
    end
    return acc;
  endfunction

  function automatic real dft_im(input vec_t x, input int k);
    real acc = 0.0;
    for (int n = 0; n < 16; n++) begin
      real ang = 2.0 * 3.141592653589793 * n * k / 16.0;
      acc += im_of(x[n]) * $cos(ang) - re_of(x[n]) * $sin(ang);
    end
    return acc;
  endfunction

  task automatic check(
    input string       tag,
    input logic [35:0] obs,
    input logic [35:0] exp
  );
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_tol(
    input string tag,
    input int    obs,
    input real   exp,
    input real   tol
  );
    real d;
    d = $itor(obs) - exp;
    compared++;
    assert (d <= tol && -d <= tol) else begin
      mismatched++;
      $error("FAIL %s: got %0d expected %f +/- %f",
             tag, obs, exp, tol);
    end
  endtask

  task automatic rand_frame(output vec_t x, input bit full);
    for (int n = 0; n < 16; n++) begin
      if (full)
        x[n] = {18'($urandom), 18'($urandom)};
      else
        x[n] = pk(int'($urandom_range(4000)) - 2000,
                  int'($urandom_range(4000)) - 2000);
    end
  endtask

  // Capture x, then count edges until done (bounded).
  task automatic run(input vec_t x, input bit hold, output int lat);
    vec_t junk;
    repeat (2) @(negedge clk);
    xin   = x;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) begin
      start = 1'b0;
      rand_frame(junk, 1'b1);
      xin = junk;
    end
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    vec_t x;
    vec_t y;
    vec_t keep;
    int   lat;
    int   cnt;

    reset = 1'b1;
    start = 1'b0;
    for (int n = 0; n < 16; n++) xin[n] = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_done", 36'(done), 36'd0);
    check("rst_out0", xout[0], 36'd0);
    check("rst_out15", xout[15], 36'd0);

    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    check("idle_done_count", 36'(cnt), 36'd0);
    check("idle_out7", xout[7], 36'd0);

    // Impulse
    for (int n = 0; n < 16; n++) x[n] = '0;
    x[0] = pk(1000, 0);
    run(x, 1'b0, lat);
    check("imp_latency", 36'(lat), 36'd4);
    for (int k = 0; k < 16; k++)
      check($sformatf("imp_out%0d", k), xout[k], pk(1000, 0));
    @(posedge clk);
    #1;
    check("imp_done_clear", 36'(done), 36'd0);

    // DC
    for (int n = 0; n < 16; n++) x[n] = pk(100, 0);
    run(x, 1'b0, lat);
    check("dc_latency", 36'(lat), 36'd4);
    for (int k = 0; k < 16; k++)
      check($sformatf("dc_out%0d", k), xout[k],
            (k == 0) ? pk(1600, 0) : pk(0, 0));

    // Alternating
    for (int n = 0; n < 16; n++)
      x[n] = pk((n % 2 == 0) ? 100 : -100, 0);
    run(x, 1'b0, lat);
    for (int k = 0; k < 16; k++)
      check($sformatf("alt_out%0d", k), xout[k],
            (k == 8) ? pk(1600, 0) : pk(0, 0));

    // Staircase, start held high
    for (int n = 0; n < 16; n++) x[n] = pk(100 * (n / 4 + 1), 0);
    run(x, 1'b1, lat);
    check("stair_latency", 36'(lat), 36'd4);
    check("stair_out0", xout[0], pk(4000, 0));
    check("stair_out4", xout[4], pk(0, 0));
    check("stair_out8", xout[8], pk(0, 0));
    check("stair_out12", xout[12], pk(0, 0));
    check_tol("stair_out2_re", re_of(xout[2]), -200.0, 2.0);
    check_tol("stair_out2_im", im_of(xout[2]), 482.84, 2.0);
    for (int k = 0; k < 16; k++) begin
      check_tol($sformatf("stair_re%0d", k), re_of(xout[k]),
                dft_re(x, k), 2.0);
      check_tol($sformatf("stair_im%0d", k), im_of(xout[k]),
                dft_im(x, k), 2.0);
    end
    for (int k = 1; k < 8; k++) begin
      check_tol($sformatf("conj_re%0d", k), re_of(xout[16 - k]),
                $itor(re_of(xout[k])), 2.0);
      check_tol($sformatf("conj_im%0d", k), im_of(xout[16 - k]),
                -$itor(im_of(xout[k])), 2.0);
    end
    model(x, y);
    for (int k = 0; k < 16; k++)
      check($sformatf("stair_model%0d", k), xout[k], y[k]);
    for (int k = 0; k < 16; k++) keep[k] = xout[k];
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (!done && cnt < 20);
    check("stair_period", 36'(cnt), 36'd6);
    for (int k = 0; k < 16; k++)
      check($sformatf("stair_repeat%0d", k), xout[k], keep[k]);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(posedge clk);

    // Random frames against the model
    for (int r = 0; r < 6; r++) begin
      rand_frame(x, r >= 4);
      run(x, 1'b0, lat);
      check($sformatf("rnd%0d_latency", r), 36'(lat), 36'd4);
      model(x, y);
      for (int k = 0; k < 16; k++)
        check($sformatf("rnd%0d_out%0d", r, k), xout[k], y[k]);
    end

    // Reset in the middle of a transform
    rand_frame(x, 1'b0);
    repeat (2) @(negedge clk);
    xin   = x;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_done", 36'(done), 36'd0);
    for (int k = 0; k < 16; k++)
      check($sformatf("midrst_out%0d", k), xout[k], 36'd0);
    @(posedge clk);
    #1;
    check("midrst_hold_out3", xout[3], 36'd0);
    @(negedge clk);
    reset = 1'b0;
    rand_frame(x, 1'b0);
    run(x, 1'b0, lat);
    check("post_rst_latency", 36'(lat), 36'd4);
    model(x, y);
    for (int k = 0; k < 16; k++)
      check($sformatf("post_rst_out%0d", k), xout[k], y[k]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
